// File: rtl/conf_reg_bank.sv
// conf_reg_bank
//   Configuration target for the CONF bus. Accepted writes are buffered in a
//   small FIFO and drained, one per cycle, into a bank of NUM_REGS registers.
//   Out-of-range addresses are dropped at drain time and counted in a
//   saturating error counter. cfg_lock freezes draining while still letting
//   the FIFO fill.
//
//   Optional feature macro: CONF_READBACK_EN
//     When defined, adds a registered read port (rd_addr -> rd_data).
//
// Ports:
//   clk, rst        clock (posedge) and asynchronous active-high reset
//   c_addr, c_data  CONF write address / data
//   c_valid         write request
//   c_ready         target can accept (FIFO not full), combinational
//   cfg_lock        hold off draining while high
//   cfg_regs        flattened register bank, reg i at [i*C_DATA_WIDTH +: C_DATA_WIDTH]
//   cfg_update      one-cycle one-hot strobe for the register just written
//   fifo_level      current FIFO occupancy
//   err_cnt         saturating count of drained out-of-range writes
//   rd_addr/rd_data (CONF_READBACK_EN only) registered register readback
module conf_reg_bank #(
  parameter int C_ADDR_WIDTH = 8,
  parameter int C_DATA_WIDTH = 32,
  parameter int NUM_REGS     = 16,
  parameter int DEPTH        = 4,
  parameter int ERR_WIDTH    = 8,
  parameter logic [C_DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [C_ADDR_WIDTH-1:0]          c_addr,
  input  logic [C_DATA_WIDTH-1:0]          c_data,
  input  logic                             c_valid,
  output logic                             c_ready,
  input  logic                             cfg_lock,
  output logic [NUM_REGS*C_DATA_WIDTH-1:0] cfg_regs,
  output logic [NUM_REGS-1:0]              cfg_update,
  output logic [$clog2(DEPTH+1)-1:0]       fifo_level,
  output logic [ERR_WIDTH-1:0]             err_cnt
`ifdef CONF_READBACK_EN
  ,
  input  logic [C_ADDR_WIDTH-1:0]          rd_addr,
  output logic [C_DATA_WIDTH-1:0]          rd_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam logic [LVL_W-1:0]        DEPTH_LVL    = LVL_W'(DEPTH);
  // One extra bit so NUM_REGS == 2**C_ADDR_WIDTH is representable.
  localparam logic [C_ADDR_WIDTH:0]   NUM_REGS_EXT = (C_ADDR_WIDTH+1)'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t state, state_next;

  logic [C_ADDR_WIDTH-1:0] fifo_addr [DEPTH];
  logic [C_DATA_WIDTH-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [LVL_W-1:0]        count, count_next;

  logic                    push, pop;
  logic [C_ADDR_WIDTH-1:0] head_addr;
  logic [C_DATA_WIDTH-1:0] head_data;
  logic                    head_in_range;
  logic [NUM_REGS-1:0]     wr_hit;

  logic [C_DATA_WIDTH-1:0] regs [NUM_REGS];

  assign c_ready       = (count < DEPTH_LVL);
  assign fifo_level    = count;
  assign push          = c_valid && c_ready;
  // DRAIN is only ever entered with a non-empty FIFO, so the state alone
  // qualifies the pop.
  assign pop           = (state == DRAIN);
  assign head_addr     = fifo_addr[rd_ptr];
  assign head_data     = fifo_data[rd_ptr];
  assign head_in_range = ({1'b0, head_addr} < NUM_REGS_EXT);

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Next state follows the post-edge occupancy and the current lock input,
  // so a write into an empty FIFO is drained on the very next edge.
  always_comb begin
    state_next = IDLE;
    if (cfg_lock)
      state_next = LOCKED;
    else if (count_next == '0)
      state_next = IDLE;
    else
      state_next = DRAIN;
  end

  // Decode of the register targeted by the entry popped this cycle.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (pop && head_in_range &&
          ({1'b0, head_addr} == (C_ADDR_WIDTH+1)'(i)))
        wr_hit[i] = 1'b1;
    end
  end

  // FIFO storage needs no reset: entries are only read while count > 0.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= c_addr;
      fifo_data[wr_ptr] <= c_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      state <= state_next;
    end
  end

  // Register bank and its update strobe change together on the pop edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= RESET_VAL;
      cfg_update <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i])
          regs[i] <= head_data;
      end
      cfg_update <= wr_hit;
    end
  end

  // Out-of-range drains bump the error count, which sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (pop && !head_in_range && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign cfg_regs[g*C_DATA_WIDTH +: C_DATA_WIDTH] = regs[g];
  end

`ifdef CONF_READBACK_EN
  logic [C_DATA_WIDTH-1:0] rd_mux;

  // Out-of-range read addresses return zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if ({1'b0, rd_addr} == (C_ADDR_WIDTH+1)'(i))
        rd_mux = regs[i];
    end
  end

  // Sampling regs before the non-blocking update gives read-before-write
  // when a drain hits the same register on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_data <= '0;
    else
      rd_data <= rd_mux;
  end
`endif

endmodule

// File: doc/conf_reg_bank.md
Name: conf_reg_bank

Overview:
Parametrised configuration target for the CONF bus (c_addr/c_data/c_valid/c_ready). It buffers accepted writes in a small FIFO and drains them into a bank of NUM_REGS configuration registers. It exposes the register contents, per-register update strobes, and a saturating error count for out-of-range addresses. It sits between the CONF bus driver and the datapath blocks that consume configuration.

Parameters:
C_ADDR_WIDTH, 8, width of c_addr
C_DATA_WIDTH, 32, width of c_data and of each register
NUM_REGS, 16, number of registers; legal addresses are 0..NUM_REGS-1; range 1..2**C_ADDR_WIDTH
DEPTH, 4, write FIFO depth; power of two, minimum 2
ERR_WIDTH, 8, width of the saturating error counter
RESET_VAL, 0, reset value of every register (C_DATA_WIDTH bits)

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  asynchronous reset, active-high
c_addr  input  C_ADDR_WIDTH  write address
c_data  input  C_DATA_WIDTH  write data
c_valid  input  1  write request
c_ready  output  1  target can accept; transfer occurs when c_valid && c_ready at posedge
cfg_lock  input  1  while high, the FIFO does not drain; writes still accepted until full
cfg_regs  output  NUM_REGS*C_DATA_WIDTH  register bank, reg i at bits [i*C_DATA_WIDTH +: C_DATA_WIDTH]
cfg_update  output  NUM_REGS  one-cycle one-hot strobe, bit i set in the cycle reg i takes a new value
fifo_level  output  $clog2(DEPTH+1)  current FIFO occupancy
err_cnt  output  ERR_WIDTH  count of drained out-of-range writes, saturating

Behaviour:
- Reset (async assert, sync-safe deassert by design): FIFO empty, fifo_level=0, c_ready=1, all regs=RESET_VAL, cfg_update=0, err_cnt=0, FSM=IDLE. Reset mid-operation discards all buffered writes; no strobe is produced for them.
- c_ready is combinational: c_ready = (fifo_level < DEPTH). Full -> c_ready=0; a c_valid held while not ready is not stored. The bus driver must hold the item until it is accepted.
- Push: c_valid && c_ready at edge N stores {c_addr,c_data} at the tail.
- FSM states:
  - IDLE: FIFO empty.
  - DRAIN: not empty and !cfg_lock.
  - LOCKED: cfg_lock=1, whatever the occupancy.
  - Transitions are evaluated every cycle from the next-state occupancy and cfg_lock.
- Pop: in DRAIN, one entry is popped per cycle at the head.
  - If addr < NUM_REGS: reg[addr] <= data and cfg_update[addr]=1 in the following cycle, coincident with the new value.
  - Else: no register changes, cfg_update=0, and err_cnt increments (holds at 2**ERR_WIDTH-1).
- Latency: into an empty, unlocked FIFO, a write accepted at edge N is popped at edge N+1. cfg_regs and cfg_update reflect it from edge N+1 onward, so it is visible in cycle N+1 (1 cycle latency). Sustained throughput is 1 write/cycle.
- Simultaneous push and pop: allowed; occupancy is unchanged. At full, no push is possible that cycle even if a pop occurs (c_ready does not look ahead).
- Ordering: strict FIFO. Two writes to the same address apply in acceptance order; the last one wins.
- Pointers wrap modulo DEPTH. Occupancy is tracked with an explicit counter (0..DEPTH).
- cfg_lock rising while entries are pending: draining stops at the next edge and the entries are retained. Lock falling: draining resumes on the next edge.
- cfg_update is zero whenever no valid pop occurred in the previous edge.

Optional Feature:
CONF_READBACK_EN
- Defined: adds ports rd_addr (input, C_ADDR_WIDTH) and rd_data (output, C_DATA_WIDTH, registered).
  - rd_data <= reg[rd_addr] one cycle after rd_addr is sampled, or 0 if out of range. Reset value is 0.
  - If a drain writes the same register at that edge, rd_data returns the old value (read-before-write).
- Not defined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset then single write addr=3 data=0xDEADBEEF, lock=0 -> reg3=0xDEADBEEF and cfg_update=0x0008 for exactly one cycle, one cycle after acceptance; other regs stay 0.
- Lock=1, issue 6 back-to-back writes (DEPTH=4) -> 4 accepted, c_ready=0 with fifo_level=4, cfg_update stays 0. Drop lock -> 4 consecutive one-cycle strobes in order, then accepted writes 5-6 drain after re-presentation.
- Writes to addr=16 and addr=255 (NUM_REGS=16) -> err_cnt=2, no register changes, no strobes. Drive 300 illegal writes -> err_cnt saturates at 255.
- Back-to-back writes addr=5 data=1 then addr=5 data=2 with continuous c_valid -> two strobes on bit 5; final reg5=2; fifo_level never exceeds 1.
- Assert rst with 3 entries pending under lock -> immediately fifo_level=0, all regs=RESET_VAL, err_cnt=0; after release and lock=0, no strobes occur.
- (CONF_READBACK_EN) Write addr=7 data=0x55, then rd_addr=7 -> rd_data=0x55 one cycle later; rd_addr=20 -> rd_data=0.
